// File: rtl/spiral_arb.sv
// spiral_arb: round-robin scheduler sharing one spiral matrix engine among
// NUM_REQ requesters; streams the granted job in and routes spiral output back.
module spiral_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            job_req,
  input  logic [NUM_REQ*R_WIDTH-1:0]    job_row,
  input  logic [NUM_REQ*C_WIDTH-1:0]    job_col,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            job_done,
  output logic [NUM_REQ-1:0]            job_err,
  output logic [R_WIDTH-1:0]            eng_row,
  output logic [C_WIDTH-1:0]            eng_col,
  output logic [DATA_WIDTH-1:0]         eng_data_in,
  output logic                          eng_data_in_valid,
  input  logic                          eng_data_in_rdy,
  input  logic [DATA_WIDTH-1:0]         eng_data_out,
  input  logic                          eng_data_out_valid,
  output logic                          eng_data_out_rdy
);
  // state | meaning
  // IDLE  | arbitrate job_req from rr_ptr+1; reject zero-sized jobs
  // LOAD  | stream the winner's row-major beats into the engine
  // DRAIN | route the engine's spiral output to the winner
  // DONE  | wait for engine idle, then pulse job_done and release
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = R_WIDTH + C_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d, w_q, w_d, win_idx;
  logic                 win_found;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, err_q, err_d;
  logic [R_WIDTH-1:0]   row_q, row_d, win_row;
  logic [C_WIDTH-1:0]   col_q, col_d, win_col;
  logic [TW-1:0]        total_q, total_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  int                   scan_idx;

  // Scan downward so the lowest offset from rr_ptr+1 is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan_idx  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (job_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(scan_idx);
      end
    end
  end

  assign win_row = job_row[win_idx*R_WIDTH +: R_WIDTH];
  assign win_col = job_col[win_idx*C_WIDTH +: C_WIDTH];

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    w_d               = w_q;
    gnt_d             = gnt_q;
    err_d             = '0;
    row_d             = row_q;
    col_d             = col_q;
    total_d           = total_q;
    in_cnt_d          = in_cnt_q;
    out_cnt_d         = out_cnt_q;
    req_rdy           = '0;
    rsp_valid         = '0;
    rsp_data          = '0;
    eng_data_in       = '0;
    eng_data_in_valid = 1'b0;
    eng_data_out_rdy  = 1'b0;
    job_done          = '0;
    case (state_q)
      IDLE: begin
        // Skip the cycle job_err is visible so the rejected requester can drop.
        if (win_found && err_q == '0) begin
          if (win_row == '0 || win_col == '0) begin
            err_d[win_idx] = 1'b1;
            rr_ptr_d       = win_idx;
          end else begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            w_d            = win_idx;
            row_d          = win_row;
            col_d          = win_col;
            total_d        = TW'(win_row) * TW'(win_col);
            in_cnt_d       = '0;
            out_cnt_d      = '0;
            state_d        = LOAD;
          end
        end
      end
      LOAD: begin
        eng_data_in       = req_data[w_q*DATA_WIDTH +: DATA_WIDTH];
        eng_data_in_valid = req_valid[w_q];
        req_rdy[w_q]      = eng_data_in_rdy;
        if (req_valid[w_q] && eng_data_in_rdy) begin
          if (in_cnt_q == total_q - TW'(1)) begin
            in_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + TW'(1);
          end
        end
      end
      DRAIN: begin
        rsp_data         = eng_data_out;
        rsp_valid[w_q]   = eng_data_out_valid;
        eng_data_out_rdy = rsp_rdy[w_q];
        if (eng_data_out_valid && rsp_rdy[w_q]) begin
          if (out_cnt_q == total_q - TW'(1)) begin
            out_cnt_d = '0;
            state_d   = DONE;
          end else begin
            out_cnt_d = out_cnt_q + TW'(1);
          end
        end
      end
      DONE: begin
        if (!eng_data_out_valid && eng_data_in_rdy) begin
          job_done = gnt_q;
          gnt_d    = '0;
          rr_ptr_d = w_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= PW'(NUM_REQ - 1);
      w_q       <= '0;
      gnt_q     <= '0;
      err_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      total_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      w_q       <= w_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      row_q     <= row_d;
      col_q     <= col_d;
      total_q   <= total_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign job_err = err_q;
  assign eng_row = row_q;
  assign eng_col = col_q;

endmodule

// File: tb/tb_spiral_arb.sv
// tb_spiral_arb: directed jobs against a behavioural spiral engine; expected
// grants and response beats are queued up front and checked by a monitor.
module tb_spiral_arb;
  localparam int N = 4, DW = 8, RW = 3, CW = 3;

  logic clk = 1'b0, rst;
  logic [N-1:0]    job_req, req_valid, req_rdy, rsp_valid, rsp_rdy, gnt, job_done, job_err;
  logic [N*RW-1:0] job_row;
  logic [N*CW-1:0] job_col;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, eng_data_in, eng_data_out;
  logic [RW-1:0]   eng_row;
  logic [CW-1:0]   eng_col;
  logic            eng_data_in_valid, eng_data_in_rdy, eng_data_out_valid, eng_data_out_rdy;

  always #5 clk = ~clk;

  spiral_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .job_req(job_req), .job_row(job_row), .job_col(job_col),
    .req_data(req_data), .req_valid(req_valid), .req_rdy(req_rdy),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_rdy(rsp_rdy),
    .gnt(gnt), .job_done(job_done), .job_err(job_err),
    .eng_row(eng_row), .eng_col(eng_col),
    .eng_data_in(eng_data_in), .eng_data_in_valid(eng_data_in_valid), .eng_data_in_rdy(eng_data_in_rdy),
    .eng_data_out(eng_data_out), .eng_data_out_valid(eng_data_out_valid), .eng_data_out_rdy(eng_data_out_rdy));

  int total = 0, bad = 0;
  int done_cnt [N];
  int err_cnt [N];
  int in_beats = 0, out_beats = 0;
  logic [7:0] exp_q [N][$];
  int exp_gnt [$];
  logic [N-1:0] prev_gnt = '0;
  bit sb_en, abort_job;
  int idle_delay;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spiral engine model: accepts row*col beats, emits them in clockwise spiral order.
  typedef enum logic [1:0] {E_IN, E_OUT, E_WAIT} e_t;
  e_t         e_st;
  logic [7:0] emem [64];
  int         e_cnt, e_wait, e_n;

  function automatic int spiral_idx(int r, int c, int k);
    int top = 0, bot = r - 1, lft = 0, rgt = c - 1, n = 0, res = 0;
    while (top <= bot && lft <= rgt) begin
      for (int j = lft; j <= rgt; j++) begin if (n == k) res = top*c + j; n++; end
      top++;
      for (int i = top; i <= bot; i++) begin if (n == k) res = i*c + rgt; n++; end
      rgt--;
      if (top <= bot) begin
        for (int j = rgt; j >= lft; j--) begin if (n == k) res = bot*c + j; n++; end
        bot--;
      end
      if (lft <= rgt) begin
        for (int i = bot; i >= top; i--) begin if (n == k) res = i*c + lft; n++; end
        lft++;
      end
    end
    return res;
  endfunction

  assign e_n                = int'(eng_row) * int'(eng_col);
  assign eng_data_in_rdy    = (e_st == E_IN);
  assign eng_data_out_valid = (e_st == E_OUT);
  assign eng_data_out       = (e_st == E_OUT) ? emem[spiral_idx(int'(eng_row), int'(eng_col), e_cnt)] : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      e_st  <= E_IN;
      e_cnt <= 0;
      e_wait <= 0;
    end else begin
      case (e_st)
        E_IN: if (eng_data_in_valid) begin
          emem[e_cnt] <= eng_data_in;
          if (e_cnt + 1 == e_n) begin e_cnt <= 0; e_st <= E_OUT; end
          else e_cnt <= e_cnt + 1;
        end
        E_OUT: if (eng_data_out_rdy) begin
          if (e_cnt + 1 == e_n) begin
            e_cnt <= 0;
            if (idle_delay > 0) begin e_st <= E_WAIT; e_wait <= idle_delay; end
            else e_st <= E_IN;
          end else e_cnt <= e_cnt + 1;
        end
        default: if (e_wait <= 1) e_st <= E_IN; else e_wait <= e_wait - 1;
      endcase
    end
  end

  // Monitor: grant order, response beats, pulses, one-hot and routing rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != prev_gnt && gnt != '0) begin
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        if (exp_gnt.size() == 0) begin
          total++; bad++;
          $display("FAIL gnt_unexpected: got %b expected no grant", gnt);
        end else check("gnt_order", 32'(gnt), 32'(1) << exp_gnt.pop_front());
      end
      if (rsp_valid != '0) check("rsp_valid_gnt", 32'(rsp_valid & ~gnt), 32'd0);
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_rdy[i]) begin
          out_beats++;
          if (sb_en) begin
            if (exp_q[i].size() == 0) begin
              total++; bad++;
              $display("FAIL rsp_unexpected: req %0d got %0h expected no beat", i, rsp_data);
            end else check($sformatf("rsp_data%0d", i), 32'(rsp_data), 32'(exp_q[i].pop_front()));
          end
        end
        if (job_done[i]) begin
          done_cnt[i]++;
          check("done_eng_idle", {30'd0, eng_data_in_rdy, eng_data_out_valid}, 32'd2);
        end
        if (job_err[i]) err_cnt[i]++;
      end
      if (eng_data_in_valid && eng_data_in_rdy) in_beats++;
    end
    prev_gnt = gnt;
  end

  // One requester job: request + first beat together, feed beats, wait done/err.
  task automatic src(int i, int rows, int cols, int base, bit gap);
    int  n = rows * cols, k = 0, t;
    bit  hs, seen = 0;
    job_row[i*RW +: RW] = RW'(rows);
    job_col[i*CW +: CW] = CW'(cols);
    job_req[i] = 1'b1;
    if (n == 0) begin
      for (t = 0; t < 50 && !seen; t++) begin
        @(negedge clk);
        seen = job_err[i];
      end
      if (!seen) begin total++; bad++; $display("FAIL err_timeout: req %0d got no job_err expected pulse", i); end
      @(posedge clk); #1;
      job_req[i] = 1'b0;
    end else begin
      req_data[i*DW +: DW] = DW'(base);
      req_valid[i] = 1'b1;
      for (t = 0; t < 400 && k < n && !abort_job; t++) begin
        @(negedge clk);
        hs = req_valid[i] && req_rdy[i];
        @(posedge clk); #1;
        if (hs) begin
          k++;
          req_data[i*DW +: DW] = DW'(base + k);
          req_valid[i] = (k < n) && !gap;
        end else if (gap && !req_valid[i]) req_valid[i] = 1'b1;
      end
      req_valid[i] = 1'b0;
      if (k < n && !abort_job) begin total++; bad++; $display("FAIL load_timeout: req %0d got %0d beats expected %0d", i, k, n); end
      for (t = 0; t < 400 && !seen && !abort_job; t++) begin
        @(negedge clk);
        seen = job_done[i];
      end
      if (abort_job) job_req[i] = 1'b0;
      else begin
        if (!seen) begin total++; bad++; $display("FAIL done_timeout: req %0d got no job_done expected pulse", i); end
        @(posedge clk); #1;
        job_req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, ob, t;
    rst = 1'b1; job_req = '0; job_row = '0; job_col = '0; req_data = '0; req_valid = '0;
    rsp_rdy = '1; sb_en = 1; abort_job = 0; idle_delay = 0;
    for (int i = 0; i < N; i++) begin done_cnt[i] = 0; err_cnt[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_req_rdy", 32'(req_rdy), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_pulses", 32'({job_done, job_err}), 0);
    check("rst_eng_hs", 32'({eng_data_in_valid, eng_data_out_rdy}), 0);
    check("rst_eng_dims", 32'({eng_row, eng_col}), 0);
    check("rst_data", 32'({rsp_data, eng_data_in}), 0);
    @(posedge clk); #1; rst = 1'b0;

    // 3x3 on req1 alone
    @(posedge clk); #1;
    exp_gnt.push_back(1);
    exp_q[1] = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd9, 8'd8, 8'd7, 8'd4, 8'd5};
    fork
      src(1, 3, 3, 1, 0);
      begin
        @(negedge clk); check("gnt_before_edge", 32'(gnt), 0);
        @(negedge clk); check("gnt_latency", 32'(gnt), 32'b0010);
        check("eng_dims_latched", 32'({eng_row, eng_col}), 32'({3'd3, 3'd3}));
      end
    join
    @(negedge clk);
    check("t1_gnt_released", 32'(gnt), 0);
    check("t1_done_cnt", done_cnt[1], 1);
    check("t1_in_beats", in_beats, 9);
    check("t1_rsp_left", exp_q[1].size(), 0);

    // Round robin from reset: 0,2,3 then re-requesting 0 goes last
    @(posedge clk); #1; rst = 1'b1;
    exp_gnt.push_back(0); exp_gnt.push_back(2); exp_gnt.push_back(3); exp_gnt.push_back(0);
    exp_q[0] = '{8'h10, 8'h11, 8'h13, 8'h12, 8'h40, 8'h41, 8'h43, 8'h42};
    exp_q[2] = '{8'h20, 8'h21, 8'h23, 8'h22};
    exp_q[3] = '{8'h30, 8'h31, 8'h33, 8'h32};
    fork
      begin src(0, 2, 2, 'h10, 0); src(0, 2, 2, 'h40, 0); end
      src(2, 2, 2, 'h20, 0);
      src(3, 2, 2, 'h30, 0);
      begin repeat (2) @(posedge clk); #1; rst = 1'b0; end
    join
    check("t2_gnt_left", exp_gnt.size(), 0);
    check("t2_done0", done_cnt[0], 2);
    check("t2_done2", done_cnt[2], 1);
    check("t2_done3", done_cnt[3], 1);
    check("t2_rsp_left", exp_q[0].size() + exp_q[2].size() + exp_q[3].size(), 0);

    // Zero column on req2 is rejected, then 1x4 on req3
    ib = in_beats;
    src(2, 2, 0, 'h50, 0);
    check("t3_err2", err_cnt[2], 1);
    check("t3_no_engine", in_beats, ib);
    check("t3_no_done", done_cnt[2], 1);
    exp_gnt.push_back(3);
    exp_q[3] = '{8'h60, 8'h61, 8'h62, 8'h63};
    src(3, 1, 4, 'h60, 0);
    check("t3_done3", done_cnt[3], 2);
    check("t3_rsp_left", exp_q[3].size(), 0);

    // 4x3 with gapped input and a 5-cycle response stall
    ib = in_beats; ob = out_beats;
    exp_gnt.push_back(1);
    exp_q[1] = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd9, 8'd12, 8'd11, 8'd10, 8'd7, 8'd4, 8'd5, 8'd8};
    fork
      src(1, 4, 3, 1, 1);
      begin
        for (t = 0; t < 300 && out_beats < ob + 4; t++) @(negedge clk);
        check("t4_reach_stall", 32'(out_beats >= ob + 4), 1);
        @(posedge clk); #1; rsp_rdy = '0;
        t = out_beats;
        repeat (5) begin
          @(negedge clk);
          check("t4_stall_rdy", 32'(eng_data_out_rdy), 0);
          check("t4_stall_hold", out_beats, t);
        end
        @(posedge clk); #1; rsp_rdy = '1;
      end
    join
    check("t4_in_beats", in_beats - ib, 12);
    check("t4_out_beats", out_beats - ob, 12);
    check("t4_rsp_left", exp_q[1].size(), 0);
    check("t4_done1", done_cnt[1], 2);

    // Reset during DRAIN of a 7x7 job, then a 1x1 job
    sb_en = 0; ob = out_beats;
    exp_gnt.push_back(0);
    fork
      src(0, 7, 7, 1, 0);
      begin
        for (t = 0; t < 400 && out_beats < ob + 20; t++) @(negedge clk);
        check("t5_reach_drain", 32'(out_beats >= ob + 20), 1);
        @(posedge clk); #1; rst = 1'b1; abort_job = 1;
        @(negedge clk); @(negedge clk);
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_hs", 32'({req_rdy, rsp_valid, eng_data_in_valid, eng_data_out_rdy}), 0);
        check("t5_rst_dims", 32'({eng_row, eng_col}), 0);
        check("t5_rst_pulses", 32'({job_done, job_err}), 0);
        @(posedge clk); #1; rst = 1'b0;
      end
    join
    abort_job = 0; sb_en = 1;
    check("t5_no_done", done_cnt[0], 2);
    exp_gnt.push_back(2);
    exp_q[2] = '{8'h5A};
    src(2, 1, 1, 'h5A, 0);
    check("t5_done2", done_cnt[2], 2);
    check("t5_rsp_left", exp_q[2].size(), 0);

    // Engine stays busy 3 cycles after its last output beat
    idle_delay = 3;
    exp_gnt.push_back(1);
    exp_q[1] = '{8'h70, 8'h71, 8'h73, 8'h72};
    fork
      src(1, 2, 2, 'h70, 0);
      begin
        for (t = 0; t < 100 && e_st != E_WAIT; t++) @(negedge clk);
        repeat (3) begin
          check("t6_gnt_held", 32'(gnt), 32'b0010);
          check("t6_no_early_done", 32'(job_done), 0);
          @(negedge clk);
        end
        check("t6_done_first_idle", 32'(job_done), 32'b0010);
      end
    join
    @(negedge clk);
    check("t6_gnt_released", 32'(gnt), 0);
    check("t6_done1", done_cnt[1], 3);
    check("t6_rsp_left", exp_q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spiral_arb.md
Name: spiral_arb

Overview:
- Round-robin job scheduler that shares one spiral matrix engine between NUM_REQ requesters.
- A requester posts a job request with matrix dimensions. The arbiter grants one job at a time and streams the requester's row-major input beats into the engine. It then routes the engine's spiral-ordered output back to that requester, and releases the engine once the engine is idle again.
- Sits between requester-side stream ports and the engine's data_in/data_out ready-valid interfaces.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, element width.
- R_WIDTH, 3, row-dimension width.
- C_WIDTH, 3, column-dimension width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- job_req  in  NUM_REQ  per-requester job request level; held until job_done or job_err.
- job_row  in  NUM_REQ*R_WIDTH  packed row count per requester; slice i = [i*R_WIDTH +: R_WIDTH].
- job_col  in  NUM_REQ*C_WIDTH  packed column count per requester.
- req_data  in  NUM_REQ*DATA_WIDTH  packed input beats.
- req_valid  in  NUM_REQ  input beat valid.
- req_rdy  out  NUM_REQ  input beat ready.
- rsp_data  out  DATA_WIDTH  output beat, shared by all requesters.
- rsp_valid  out  NUM_REQ  output beat valid; only the granted bit can be 1.
- rsp_rdy  in  NUM_REQ  output beat ready.
- gnt  out  NUM_REQ  one-hot grant; all zero when no job is active.
- job_done  out  NUM_REQ  1-cycle pulse when a job completes.
- job_err  out  NUM_REQ  1-cycle pulse when a job is rejected because row==0 or col==0.
- eng_row  out  R_WIDTH  latched rows to the engine.
- eng_col  out  C_WIDTH  latched columns to the engine.
- eng_data_in  out  DATA_WIDTH  engine input data.
- eng_data_in_valid  out  1  engine input valid.
- eng_data_in_rdy  in  1  engine input ready.
- eng_data_out  in  DATA_WIDTH  engine output data.
- eng_data_out_valid  in  1  engine output valid.
- eng_data_out_rdy  out  1  engine output ready.

Behaviour:
- Reset state:
  - state=IDLE; rr_ptr=NUM_REQ-1.
  - gnt, req_rdy, rsp_valid, job_done, job_err, eng_data_in_valid, eng_data_out_rdy = 0.
  - eng_row, eng_col, rsp_data, eng_data_in = 0.
  - in_cnt=out_cnt=0.
  - Reset mid-job aborts the job silently with no done or err pulse. The engine must be reset in the same cycle.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE, arbitration:
  - Scan job_req starting at rr_ptr+1, wrapping modulo NUM_REQ. The first set bit wins (index w).
  - If job_row[w]==0 or job_col[w]==0: pulse job_err[w] next cycle, set rr_ptr=w, stay IDLE.
  - Otherwise, registered on the next edge: gnt=onehot(w), eng_row/eng_col latched, total=row*col (R_WIDTH+C_WIDTH bits, no overflow possible), state=LOAD.
  - Arbitration-to-first-beat latency is 1 cycle.
  - Dimension inputs are ignored after latching; eng_row/eng_col stay stable for the whole job.
- LOAD:
  - eng_data_in = req_data[w]; eng_data_in_valid = req_valid[w]; req_rdy[w] = eng_data_in_rdy. All of these are combinational.
  - All other req_rdy bits are 0.
  - Each handshake increments in_cnt. The handshake with in_cnt==total-1 moves to DRAIN and clears in_cnt.
- DRAIN:
  - rsp_data = eng_data_out; rsp_valid[w] = eng_data_out_valid; eng_data_out_rdy = rsp_rdy[w]. All combinational.
  - Each handshake increments out_cnt. The handshake with out_cnt==total-1 moves to DONE.
  - Engine output beats arriving during LOAD are not accepted (eng_data_out_rdy=0).
- DONE:
  - Hold gnt until eng_data_out_valid==0 and eng_data_in_rdy==1, i.e. the engine is back at idle.
  - In that cycle: pulse job_done[w], clear gnt, set rr_ptr=w, go to IDLE.
  - A new grant therefore comes at least 1 cycle after job_done.
- Backpressure: any cycle with valid&!rdy holds the counters; data and valid must be held by the source.
- Fairness:
  - A requester that keeps job_req high after job_done is considered last in the next scan.
  - Any requester with a pending job is granted within NUM_REQ-1 intervening jobs.
- Simultaneous events: if job_req for the granted requester drops mid-job, the job continues; the request is only sampled in IDLE.
- rsp_data is don't-care when no rsp_valid bit is set.

Test Plan:
- Req1 only, 3x3, data 1..9 → gnt=0010 one cycle after the request; 9 beats loaded; 9 beats out in spiral order 1,2,3,6,9,8,7,4,5; one job_done[1] pulse; gnt=0.
- Req0, req2 and req3 all requesting 2x2 at reset (rr_ptr=3) → grant order 0, 2, 3. With req0 re-requesting after its job, the order is 0, 2, 3, 0.
- Req2 requesting with col=0 → job_err[2] pulse, no gnt, no engine activity. Then a 1x4 job on req3 is granted next.
- 4x3 job with req_valid toggled every other cycle and rsp_rdy low for 5 cycles mid-drain → exactly 12 beats in and 12 out, no loss or duplication, and counters hold while stalled.
- rst asserted during DRAIN of a 7x7 job (out_cnt=20) → next cycle all outputs at reset values, no job_done pulse; a following 1x1 job completes normally.
- Engine holds eng_data_in_rdy=0 for 3 cycles after the last output beat → gnt held in DONE, and job_done fires in the first cycle the engine is idle.
